// File: rtl/lcd_bus_arbiter.sv
// Two-requester round-robin arbiter driving an HD44780-style LCD bus.
// Define LCD_INIT_EN to run the built-in controller init sequence after power-up.
module lcd_bus_arbiter #(
    parameter int SETUP_CYC  = 2,
    parameter int EN_CYC     = 16,
    parameter int CMD_WAIT   = 2000,
    parameter int CLR_WAIT   = 82000,
    parameter int PWRUP_WAIT = 750000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       req0_valid,
    input  logic [8:0] req0_word,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [8:0] req1_word,
    output logic       req1_ready,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA_O,
    output logic       busy,
    output logic       init_done
);

    typedef enum logic [2:0] {
        PWRUP     = 3'd0,
`ifdef LCD_INIT_EN
        INIT_LOAD = 3'd1,
`endif
        IDLE      = 3'd2,
        SETUP     = 3'd3,
        PULSE     = 3'd4,
        WAIT      = 3'd5
    } state_t;

    localparam logic [19:0] SETUP_LAST = 20'(SETUP_CYC - 1);
    localparam logic [19:0] EN_LAST    = 20'(EN_CYC - 1);
    localparam logic [19:0] CMD_LAST   = 20'(CMD_WAIT - 1);
    localparam logic [19:0] CLR_LAST   = 20'(CLR_WAIT - 1);
    localparam logic [19:0] PWRUP_LAST = 20'(PWRUP_WAIT - 1);

    state_t      state_q;
    logic [19:0] cnt_q;
    logic [8:0]  word_q;
    logic        en_q;
    logic        busy_q;
    logic        done_q;
    logic        last_q;
`ifdef LCD_INIT_EN
    logic [3:0]  idx_q;

    function automatic logic [8:0] init_word(input logic [2:0] i);
        logic [8:0] w;
        case (i)
            3'd0, 3'd1, 3'd2: w = 9'h030;
            3'd3:             w = 9'h038;
            3'd4:             w = 9'h00C;
            3'd5:             w = 9'h001;
            3'd6:             w = 9'h006;
            default:          w = 9'h080;
        endcase
        return w;
    endfunction
`endif

    logic        grant_d;
    logic        xfer_d;
    logic        is_clr_d;
    logic [19:0] wait_last_d;

    // Tie goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        grant_d = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_d = ~last_q;
        end else if (req1_valid) begin
            grant_d = 1'b1;
        end
        xfer_d   = (state_q == IDLE) && (req0_valid || req1_valid);
        is_clr_d = !word_q[8] && (word_q[7:0] >= 8'h01) && (word_q[7:0] <= 8'h03);
        wait_last_d = is_clr_d ? CLR_LAST : CMD_LAST;
    end

    assign req0_ready = (state_q == IDLE) && req0_valid && !grant_d;
    assign req1_ready = (state_q == IDLE) && req1_valid && grant_d;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= PWRUP;
            cnt_q   <= '0;
            word_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            last_q  <= 1'b1;
`ifdef LCD_INIT_EN
            idx_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                PWRUP: begin
                    if (cnt_q == PWRUP_LAST) begin
                        cnt_q <= '0;
`ifdef LCD_INIT_EN
                        state_q <= INIT_LOAD;
`else
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end
`ifdef LCD_INIT_EN
                INIT_LOAD: begin
                    if (idx_q == 4'd8) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        word_q  <= init_word(idx_q[2:0]);
                        idx_q   <= idx_q + 4'd1;
                        state_q <= SETUP;
                    end
                end
`endif
                IDLE: begin
                    if (xfer_d) begin
                        word_q  <= grant_d ? req1_word : req0_word;
                        last_q  <= grant_d;
                        state_q <= SETUP;
                        busy_q  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q   <= '0;
                        en_q    <= 1'b1;
                        state_q <= PULSE;
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end
                PULSE: begin
                    if (cnt_q == EN_LAST) begin
                        cnt_q   <= '0;
                        en_q    <= 1'b0;
                        state_q <= WAIT;
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end
                WAIT: begin
                    if (cnt_q == wait_last_d) begin
                        cnt_q <= '0;
                        if (done_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
`ifdef LCD_INIT_EN
                            state_q <= INIT_LOAD;
`else
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end
                default: begin
                    state_q <= PWRUP;
                    cnt_q   <= '0;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign LCD_EN     = en_q;
    assign LCD_RS     = word_q[8];
    assign LCD_DATA_O = word_q[7:0];
    assign LCD_RW     = 1'b0;
    assign busy       = busy_q;
    assign init_done  = done_q;

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, RS/DATA setup cycles before LCD_EN rises.
REQ-002 SHALL have parameter EN_CYC, default 16, LCD_EN high-pulse width in cycles.
REQ-003 SHALL have parameter CMD_WAIT, default 2000, post-pulse wait for ordinary transfers (40 us at 50 MHz).
REQ-004 SHALL have parameter CLR_WAIT, default 82000, post-pulse wait for clear/home commands (1.64 ms).
REQ-005 SHALL have parameter PWRUP_WAIT, default 750000, power-up delay before the first transfer (15 ms).
REQ-006 One clock; reset is synchronous and active-high; ports: CLOCK_50 input 1, the single clock; RESET input 1, synchronous active-high reset.
REQ-007 SHALL have port req0_valid, input, 1 bit: requester 0 has a word pending.
REQ-008 SHALL have port req0_word, input, 9 bits: {RS, DATA[7:0]} from requester 0.
REQ-009 SHALL have port req0_ready, output, 1 bit: requester 0 word is accepted this cycle.
REQ-010 SHALL have ports req1_valid, req1_word and req1_ready, with the same directions, widths and meanings as the requester 0 ports.
REQ-011 SHALL have output ports LCD_EN, LCD_RS and LCD_RW, each 1 bit, driving the LCD strobe, register select and read/write lines.
REQ-012 SHALL have port LCD_DATA_O, output, 8 bits: LCD data bus value.
REQ-013 SHALL have port busy, output, 1 bit: high when the FSM is not in IDLE.
REQ-014 SHALL have port init_done, output, 1 bit: high once initialisation is complete.

Function
REQ-015 FSM states SHALL be PWRUP, INIT_LOAD, IDLE, SETUP, PULSE, WAIT.
REQ-016 PWRUP SHALL count PWRUP_WAIT cycles, then go to INIT_LOAD (macro defined) or IDLE (macro undefined).
REQ-017 In IDLE, reqN_ready SHALL equal reqN_valid AND grant==N, combinationally; a transfer occurs when valid and ready are both high.
REQ-018 Grant SHALL be round-robin: if exactly one requester is valid, that requester is granted; if both are valid, the requester not granted last is granted.
REQ-019 On a transfer, the accepted word SHALL be latched, last_grant SHALL be updated, and the next state SHALL be SETUP.
REQ-020 At most one ready SHALL be high in any cycle; both readys SHALL be 0 outside IDLE.
REQ-021 SETUP SHALL drive LCD_RS/LCD_DATA_O from the latch with LCD_EN=0 for SETUP_CYC cycles, then go to PULSE.
REQ-022 PULSE SHALL hold LCD_EN=1 for exactly EN_CYC cycles, then go to WAIT with LCD_EN=0.
REQ-023 WAIT length SHALL be CLR_WAIT if RS=0 and DATA is 0x01, 0x02 or 0x03, else CMD_WAIT; at expiry the next state SHALL be INIT_LOAD if init is pending, else IDLE.
REQ-024 LCD_RS and LCD_DATA_O SHALL hold the last value through WAIT and IDLE (hold time is guaranteed).
REQ-025 LCD_RW SHALL be constant 0.
REQ-026 Delay counters SHALL be 20 bits, count up from 0, and compare with equality; there SHALL be no wrap-around within a state.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 A request that arrives while busy SHALL remain pending and SHALL NOT be lost; the requester holds valid and word stable until ready.

Reset
REQ-029 On RESET=1 at a CLOCK_50 edge: state=PWRUP, counters=0, LCD_EN=0, LCD_RS=0, LCD_DATA_O=0x00, both readys=0, busy=1, init_done=0, last_grant=1 (requester 0 wins the first tie), and the init index=0.
REQ-030 RESET SHALL take effect mid-pulse or mid-wait, dropping LCD_EN on the next edge and discarding the latched word.

Configuration
REQ-031 With macro LCD_INIT_EN defined, INIT_LOAD SHALL issue the internal sequence 0x030, 0x030, 0x030, 0x038, 0x00C, 0x001, 0x006, 0x080 through SETUP/PULSE/WAIT, then set init_done=1 and enter IDLE; requesters SHALL NOT be served before this completes.
REQ-032 With macro LCD_INIT_EN undefined, INIT_LOAD SHALL be absent, init_done SHALL be set on PWRUP expiry, and the first requester word SHALL be the first bus transfer.

Verification (parameters reduced: SETUP_CYC=2, EN_CYC=4, CMD_WAIT=10, CLR_WAIT=30, PWRUP_WAIT=20)
REQ-033 Scenario: reset, no requests, LCD_INIT_EN defined -> exactly 8 LCD_EN pulses of 4 cycles with data 30,30,30,38,0C,01,06,80; the gap after 01 is 30 cycles, other gaps are 10; init_done is then 1.
REQ-034 Scenario: req0_word=0x154 valid in IDLE -> req0_ready pulses for 1 cycle; RS=1 and DATA=0x54 2 cycles before LCD_EN rises; busy returns to 0 after 2+4+10 cycles.
REQ-035 Scenario: both requesters held valid (0x141 and 0x132) -> grants alternate 0,1,0,1 and no ready is asserted while busy.
REQ-036 Scenario: req1_word=0x001 -> post-pulse wait is 30 cycles; req1_word=0x0C4 -> wait is 10 cycles.
REQ-037 Scenario: RESET asserted in the 2nd PULSE cycle -> LCD_EN=0 next cycle, state=PWRUP, and the init sequence restarts from 0x030.
